// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//
// Operand/result bundle for the bit-serial subtractor.
//
//   Load      start strobe, active-high (master -> slave)
//   A         minuend, WIDTH bits        (master -> slave)
//   B         subtrahend, WIDTH bits     (master -> slave)
//   D         registered difference A - B mod 2^WIDTH (slave -> master)
//   Borrow    unsigned borrow-out, 1 iff A < B        (slave -> master)
//   Overflow  signed overflow of A - B                (slave -> master)
//   Busy      subtraction in progress                 (slave -> master)
//   Done      one-cycle pulse, results valid          (slave -> master)
//
// The master modport is the operand source (board top level / testbench),
// the slave modport is the subtractor itself.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             Load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             Borrow;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Load, A, B,
        input  D, Borrow, Overflow, Busy, Done
    );

    modport slave (
        input  Load, A, B,
        output D, Borrow, Overflow, Busy, Done
    );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor D = A - B. Operands are captured on
// an accepted Load, then one bit per clock is processed LSB first through a
// single full-subtractor cell with a registered borrow. After WIDTH shift
// cycles the difference, unsigned borrow and signed overflow are registered
// and Done pulses for one cycle.
//
// Ports:
//   Clock    system clock, rising-edge active
//   Resetn   asynchronous, active-low reset
//   bus      serial_subtractor_if.slave
//              Load/A/B in; D/Borrow/Overflow/Busy/Done out
//
// Load is accepted in IDLE and in DONE (back-to-back operation, one result
// every WIDTH+1 cycles); while Busy it is ignored.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    serial_subtractor_if.slave   bus
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;          // minuend shift register
    logic [WIDTH-1:0] sb;          // subtrahend shift register
    logic [WIDTH-1:0] res;         // partial result, filled from the MSB end
    logic             bor;         // registered borrow between bit slices
    logic [CW-1:0]    count;
    logic             a_sign;
    logic             b_sign;

    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             overflow_q;

    logic             busy;
    logic             done;

    // Full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             bor_next;
    logic [WIDTH-1:0] d_final;
    logic             start;

    assign d_bit    = sa[0] ^ sb[0] ^ bor;
    assign bor_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
    // Result as it will look once this cycle's bit has been shifted in.
    assign d_final  = {d_bit, res[WIDTH-1:1]};
    assign start    = bus.Load && ((state == IDLE) || (state == DONE));

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: state_next gets a default before the case so that no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.Load) state_next = SHIFT;
            SHIFT:   if (count == LAST) state_next = DONE;
            DONE:    state_next = bus.Load ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    // NOTE: every datapath register is reset, not just the FSM, so an operation
    // abandoned by reset leaves no residue in the shift chain or outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            bor        <= 1'b0;
            count      <= '0;
            a_sign     <= 1'b0;
            b_sign     <= 1'b0;
            d_q        <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start) begin
            sa     <= bus.A;
            sb     <= bus.B;
            res    <= '0;
            bor    <= 1'b0;
            count  <= '0;
            a_sign <= bus.A[WIDTH-1];
            b_sign <= bus.B[WIDTH-1];
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            res   <= d_final;
            bor   <= bor_next;
            count <= count + 1'b1;
            // Visible results change only on the transition into DONE.
            if (count == LAST) begin
                d_q        <= d_final;
                borrow_q   <= bor_next;
                overflow_q <= (a_sign != b_sign) && (d_bit != a_sign);
            end
        end
    end

    assign bus.D        = d_q;
    assign bus.Borrow   = borrow_q;
    assign bus.Overflow = overflow_q;
    assign bus.Busy     = busy;
    assign bus.Done     = done;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH = 8). The driver pushes the
// expected {D, Borrow, Overflow} whenever it starts an operation; a separate
// monitor pops and compares on every Done pulse. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             borrow;
        logic             overflow;
    } result_t;

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;
    int   cyc;

    result_t exp_q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------ monitor
    always @(negedge Clock) begin
        if (Resetn && bus.Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("D",        32'(bus.D),        32'(e.d));
                check("Borrow",   32'(bus.Borrow),   32'(e.borrow));
                check("Overflow", 32'(bus.Overflow), 32'(e.overflow));
            end
        end
    end

    // ------------------------------------------------------------------- driver
    function automatic result_t model(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        result_t r;
        r.d        = a - b;
        r.borrow   = (a < b);
        r.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (r.d[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Pulse Load for one edge; expects to be called 1 ns after a rising edge.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.A    = a;
        bus.B    = b;
        bus.Load = 1'b1;
        @(posedge Clock); #1;
        bus.Load = 1'b0;
    endtask

    // Waits (bounded) for Done at a falling edge; reports Busy cycles seen.
    task automatic wait_done(output int busy_cycles, output int done_cyc);
        logic seen;
        seen        = 1'b0;
        busy_cycles = 0;
        done_cyc    = 0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            @(negedge Clock);
            if (bus.Done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (bus.Busy) busy_cycles++;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] d, input logic bo,
                            input logic ov);
        int bc, dc;
        exp_q.push_back('{d: d, borrow: bo, overflow: ov});
        start(a, b);
        wait_done(bc, dc);
        check("busy_cycles", 32'(bc), 32'(WIDTH));
        @(posedge Clock); #1;
    endtask

    initial begin
        int bc, dc, prev_dc;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        Resetn   = 1'b0;
        bus.Load = 1'b0;
        bus.A    = '0;
        bus.B    = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_D",    32'(bus.D),        32'd0);
        check("rst_flag", 32'({bus.Borrow, bus.Overflow, bus.Busy, bus.Done}), 32'd0);
        Resetn = 1'b1;
        @(posedge Clock); #1;

        // Hand-computed directed vectors.
        directed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        directed(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        directed(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        directed(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Load while busy must be ignored (no restart, no recapture).
        exp_q.push_back('{d: 8'h0F, borrow: 1'b0, overflow: 1'b0});
        start(8'h10, 8'h01);
        @(posedge Clock); #1;
        bus.A    = 8'hFF;
        bus.B    = 8'hFF;
        bus.Load = 1'b1;
        @(posedge Clock); #1;
        bus.Load = 1'b0;
        wait_done(bc, dc);
        @(negedge Clock);
        check("idle_after_ignored_load", 32'({bus.Busy, bus.Done}), 32'd0);
        @(posedge Clock); #1;

        // Reset mid-operation: outputs clear at once, no Done follows.
        start(8'hAA, 8'h55);
        repeat (3) @(posedge Clock);
        #1;
        check("pre_rst_busy", 32'(bus.Busy), 32'd1);
        Resetn = 1'b0;
        #1;
        check("abort_D",    32'(bus.D),        32'd0);
        check("abort_flag", 32'({bus.Borrow, bus.Overflow, bus.Busy, bus.Done}), 32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge Clock);
            if (bus.Done || bus.Busy) begin
                check("no_done_after_abort", 32'({bus.Busy, bus.Done}), 32'd0);
                break;
            end
        end
        @(posedge Clock); #1;
        directed(8'h01, 8'h01, 8'h00, 1'b0, 1'b0);

        // Load held high: one result every WIDTH+1 cycles.
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{d: 8'h05, borrow: 1'b0, overflow: 1'b0});
        bus.A    = 8'h09;
        bus.B    = 8'h04;
        bus.Load = 1'b1;
        prev_dc  = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(bc, dc);
            if (i > 0) check("done_period", 32'(dc - prev_dc), 32'(WIDTH + 1));
            prev_dc = dc;
        end
        bus.Load = 1'b0;  // at the falling edge of the third Done cycle
        @(posedge Clock); #1;

        // Randomized sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] a, b;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            exp_q.push_back(model(a, b));
            start(a, b);
            wait_done(bc, dc);
            @(posedge Clock); #1;
        end

        repeat (4) @(posedge Clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1);
    end

endmodule : tb_serial_subtractor
